stream_rr_arbiter: RTL
======================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, the number of requester streams (2..16).
REQ-002 The block SHALL have parameter Datawidth, default 16, the beat width in bits, matching the downstream fifo.
REQ-003 The block SHALL have one clock and synchronous, active-high reset, on ports clk_i and rst_i.
REQ-004 Ports SHALL be:
  clk_i  input  1  clock, all state on rising edge
  rst_i  input  1  synchronous active-high reset
  data_in_i  input  NumReq*Datawidth  requester beats, requester k at bits [k*Datawidth +: Datawidth]
  data_in_valid_i  input  NumReq  per-requester valid
  data_in_last_i  input  NumReq  per-requester end-of-burst flag
  data_in_ready_o  output  NumReq  per-requester ready
  data_out_o  output  Datawidth  selected beat, to fifo data_in_i
  data_out_last_o  output  1  selected last flag
  data_out_valid_o  output  1  to fifo data_in_valid_i
  data_out_ready_i  input  1  from fifo data_in_ready_o
  grant_o  output  NumReq  one-hot current selection, zero when none
  busy_o  output  1  high while a burst is locked

Function
REQ-005 Handshake: a beat SHALL transfer on a rising edge where data_out_valid_o and data_out_ready_i are both high; per requester k, transfer iff data_in_valid_i[k] & data_in_ready_o[k].
REQ-006 The datapath SHALL be zero-latency: data_out_o, data_out_last_o and data_out_valid_o equal the selected requester's inputs in the same cycle, with no registering.
REQ-007 data_in_ready_o[k] SHALL be data_out_ready_i when k is selected, and 0 otherwise; at most one ready bit high per cycle.
REQ-008 The state machine SHALL have two states: IDLE and LOCKED.
REQ-009 In IDLE, selection SHALL be the first valid requester searching ptr, ptr+1, ..., modulo NumReq; when no requester is valid, there SHALL be no selection, grant_o=0 and data_out_valid_o=0.
REQ-010 In IDLE, a transfer with last=1 SHALL keep IDLE and set ptr to (sel+1) mod NumReq.
REQ-011 In IDLE, a transfer with last=0 SHALL enter LOCKED and store sel in grant_q; ptr stays unchanged.
REQ-012 In LOCKED, the selection SHALL be grant_q regardless of other valids; if data_in_valid_i[grant_q]=0, data_out_valid_o=0 and the state is held (no timeout).
REQ-013 In LOCKED, a transfer with last=1 SHALL enter IDLE and set ptr to (grant_q+1) mod NumReq.
REQ-014 Selection SHALL NOT change while data_out_valid_o=1 and data_out_ready_i=0 (fifo full); valid/data of the held beat remain stable as long as the requester holds them.
REQ-015 ptr SHALL wrap from NumReq-1 to 0; an idle cycle with no transfer SHALL not change ptr.
REQ-016 busy_o SHALL be 1 exactly in LOCKED; grant_o SHALL be one-hot of the selection, including in LOCKED with the grantee's valid low.

Reset
REQ-017 While rst_i=1, data_out_valid_o, data_in_ready_o, grant_o and busy_o SHALL be 0, forced combinationally, with no transfer.
REQ-018 On a clock edge with rst_i=1: state=IDLE, ptr=0, grant_q=0; reset mid-burst SHALL abandon the lock with no partial-burst recovery.

Structure
REQ-019 Package stream_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the default NumReq/Datawidth constants.
REQ-020 Rotating priority search SHALL be a sub-module rr_priority_select (inputs req vector, ptr; outputs one-hot grant, index, any).
REQ-021 The block SHALL instantiate directly in front of fifo with no glue logic.

Verification
REQ-022 Fairness: all 4 requesters valid, single-beat bursts (last=1), out_ready=1 -> grants 0,1,2,3,0,1... one per cycle.
REQ-023 Burst lock: req1 sends 3 beats (last on third) while req0/req2 valid -> grant_o=0010 for all 3 transfers, busy_o=1 after beat 1, next grant is req2.
REQ-024 Backpressure: fifo Depth=8 filled, out_ready=0 for 5 cycles with req3 selected -> grant_o stable, data_out_o unchanged, no ready high.
REQ-025 Wrap: ptr=3, only req0 and req3 valid, single beats -> order 3,0,3,0.
REQ-026 Reset mid-burst: rst_i for 1 cycle after beat 2 of a 4-beat burst from req2 -> busy_o=0, next IDLE grant starts search at req0.
REQ-027 Scoreboard: random valid/last/out_ready, 500 beats through fifo -> per-requester order preserved, no burst interleaving, zero errors.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and default sizing for the round-robin stream arbiter.
package stream_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT    = 4;
    localparam int unsigned DATA_WIDTH_DEFAULT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority pick: first asserted request at or after ptr_i, wrapping modulo NumReq.
module rr_priority_select #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic [NumReq-1:0]         grant_o,
    output logic [$clog2(NumReq)-1:0] idx_o,
    output logic                      any_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdxW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter with burst locking; zero-latency datapath feeding a fifo.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned NumReq    = NUM_REQ_DEFAULT,
    parameter int unsigned Datawidth = DATA_WIDTH_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq*Datawidth-1:0] data_in_i,
    input  logic [NumReq-1:0]           data_in_valid_i,
    input  logic [NumReq-1:0]           data_in_last_i,
    output logic [NumReq-1:0]           data_in_ready_o,
    output logic [Datawidth-1:0]        data_out_o,
    output logic                        data_out_last_o,
    output logic                        data_out_valid_o,
    input  logic                        data_out_ready_i,
    output logic [NumReq-1:0]           grant_o,
    output logic                        busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic            hold_q, hold_d;

    logic [NumReq-1:0] rr_grant;
    logic [IdxW-1:0]   rr_idx;
    logic              rr_any;

    logic [NumReq-1:0] sel_onehot;
    logic [IdxW-1:0]   sel_idx;
    logic [IdxW-1:0]   sel_inc;
    logic              sel_any;
    logic              sel_valid;
    logic              xfer;

    rr_priority_select #(
        .NumReq(NumReq)
    ) u_rr_select (
        .req_i  (data_in_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(rr_grant),
        .idx_o  (rr_idx),
        .any_o  (rr_any)
    );

    // A stalled IDLE beat is pinned through grant_q/hold_q so a newly valid,
    // higher-priority requester cannot steal the selection while the fifo is full.
    always_comb begin
        sel_idx    = rr_idx;
        sel_any    = rr_any;
        sel_onehot = rr_grant;
        if (state_q == LOCKED || (hold_q && data_in_valid_i[grant_q])) begin
            sel_idx             = grant_q;
            sel_any             = 1'b1;
            sel_onehot          = '0;
            sel_onehot[grant_q] = 1'b1;
        end
        if (rst_i) begin
            sel_any = 1'b0;
        end
    end

    assign sel_valid        = sel_any & data_in_valid_i[sel_idx];
    assign xfer             = sel_valid & data_out_ready_i;
    assign sel_inc          = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;

    assign data_out_o       = data_in_i[32'(sel_idx) * Datawidth +: Datawidth];
    assign data_out_last_o  = data_in_last_i[sel_idx];
    assign data_out_valid_o = sel_valid;
    assign grant_o          = sel_any ? sel_onehot : '0;
    assign data_in_ready_o  = grant_o & {NumReq{data_out_ready_i}};
    assign busy_o           = (state_q == LOCKED) & ~rst_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        hold_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (data_out_last_o) begin
                        ptr_d = sel_inc;
                    end else begin
                        state_d = LOCKED;
                        grant_d = sel_idx;
                    end
                end else if (sel_valid) begin
                    hold_d  = 1'b1;
                    grant_d = sel_idx;
                end
            end
            LOCKED: begin
                if (xfer && data_out_last_o) begin
                    state_d = IDLE;
                    ptr_d   = sel_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

endmodule
